led_breather: RTL and testbench

- Drives the board LED from the 100 MHz sysClk domain (PLL output behind BUFG) with selectable brightness patterns: off, on, blink and breathe.
- Contains a cascaded prescaler, PWM counter and step divider, plus a rise/fall FSM that ramps a brightness level.
- Produces a glitch-free registered PWM on `led`.
- Sits directly downstream of the clock/PLL top and replaces the bare counter-toggle LED path.

---
 rtl/led_pkg.sv | 7 +
 rtl/tick_div.sv | 26 ++
 rtl/led_breather.sv | 122 ++++++++++++
 tb/tb_led_breather.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED breather: output pattern select and ramp direction.
package led_pkg;

    typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE} mode_t;
    typedef enum logic {RISE, FALL} state_t;

endpackage

// File: rtl/tick_div.sv
// Wrapping modulo-DIV counter; tick marks the increment that wraps it.
module tick_div #(
    parameter int DIV = 2
) (
    input  logic sysClk,
    input  logic rstN,
    input  logic inc,
    output logic tick
);

    // DIV=1 still needs a 1-bit counter that simply stays at zero
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = inc && (cnt == LAST);

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN)
            cnt <= '0;
        else if (inc)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/led_breather.sv
// LED pattern generator: prescaled PWM carrier, triangle brightness ramp and
// a period-aligned duty shadow feeding a registered LED output.
module led_breather
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 390,
    parameter int STEP_DIV = 2
) (
    input  logic                sysClk,
    input  logic                rstN,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic                led,
    output logic                periodStart,
    output logic [PWM_BITS-1:0] level
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic                pwmTick;
    logic                periodEnd;
    logic                stepTick;
    logic [PWM_BITS-1:0] pwmCnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] dutySel;
    logic [PWM_BITS-1:0] levelNxt;
    state_t              state, stateNxt;

    tick_div #(.DIV(PRESCALE)) u_pre (
        .sysClk (sysClk),
        .rstN   (rstN),
        .inc    (1'b1),
        .tick   (pwmTick)
    );

    tick_div #(.DIV(STEP_DIV)) u_step (
        .sysClk (sysClk),
        .rstN   (rstN),
        .inc    (periodEnd),
        .tick   (stepTick)
    );

    assign periodEnd = pwmTick && (pwmCnt == MAX);

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            pwmCnt      <= '0;
            periodStart <= 1'b0;
        end else begin
            periodStart <= periodEnd;
            if (pwmTick)
                pwmCnt <= pwmCnt + 1'b1;
        end
    end

    // Ramp bounces off the extremes without dwelling on them
    always_comb begin
        stateNxt = state;
        levelNxt = level;
        if (stepTick) begin
            case (state)
                RISE: begin
                    if (level == MAX) begin
                        stateNxt = FALL;
                        levelNxt = MAX - 1'b1;
                    end else begin
                        levelNxt = level + 1'b1;
                    end
                end
                FALL: begin
                    if (level == '0) begin
                        stateNxt = RISE;
                        levelNxt = PWM_BITS'(1);
                    end else begin
                        levelNxt = level - 1'b1;
                    end
                end
                default: stateNxt = RISE;
            endcase
        end
    end

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            state <= RISE;
            level <= '0;
        end else begin
            state <= stateNxt;
            level <= levelNxt;
        end
    end

    always_comb begin
        dutySel = '0;
        case (mode_t'(mode))
            MODE_OFF:     dutySel = '0;
            MODE_ON:      dutySel = MAX;
            MODE_BLINK:   dutySel = (state == RISE) ? MAX : '0;
            MODE_BREATHE: dutySel = level;
            default:      dutySel = '0;
        endcase
    end

    // Duty is only reloaded at period boundaries so the carrier never glitches
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            duty <= '0;
            led  <= 1'b0;
        end else begin
            if (periodEnd)
                duty <= dutySel;
            if (!en)
                led <= 1'b0;
            else if (duty == MAX)
                led <= 1'b1;
            else
                led <= (pwmCnt < duty);
        end
    end

endmodule

// File: tb/tb_led_breather.sv
// Self-checking bench for led_breather with a closed-form cycle model.
module tb_led_breather;

    localparam int P     = 2;
    localparam int SD    = 2;
    localparam int MAXV  = 7;
    localparam int PER   = P * (MAXV + 1);
    localparam int STEPC = PER * SD;
    localparam int TRI   = 2 * MAXV;

    logic       sysClk = 1'b0;
    logic       rstN   = 1'b0;
    logic       en     = 1'b0;
    logic [1:0] mode   = 2'd0;
    logic       led;
    logic       periodStart;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    int n      = 0;   // clock edges since last reset release
    int mDuty  = 0;
    bit mLed   = 1'b0;

    led_breather #(.PWM_BITS(3), .PRESCALE(P), .STEP_DIV(SD)) dut (
        .sysClk      (sysClk),
        .rstN        (rstN),
        .en          (en),
        .mode        (mode),
        .led         (led),
        .periodStart (periodStart),
        .level       (level)
    );

    always #5 sysClk = ~sysClk;

    // Triangle ramp: step s -> 0,1..MAX,MAX-1..0,1..
    function automatic int levelAt(int k);
        int s;
        s = (k / STEPC) % TRI;
        return (s <= MAXV) ? s : TRI - s;
    endfunction

    function automatic bit riseAt(int k);
        int s;
        s = k / STEPC;
        return (s == 0) || ((s % TRI) >= 1 && (s % TRI) <= MAXV);
    endfunction

    function automatic int dutyFor(int md, int k);
        case (md)
            0:       return 0;
            1:       return MAXV;
            2:       return riseAt(k) ? MAXV : 0;
            default: return levelAt(k);
        endcase
    endfunction

    // Advance one clock and the model; leaves time 1 unit after the edge
    task automatic tick();
        bit e;
        int md;
        e  = en;
        md = int'(mode);
        @(posedge sysClk);
        n++;
        if (!e)
            mLed = 1'b0;
        else if (mDuty == MAXV)
            mLed = 1'b1;
        else
            mLed = (((n - 1) / P) % (MAXV + 1)) < mDuty;
        if (n % PER == 0)
            mDuty = dutyFor(md, n - 1);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        rstN  = 1'b1;
        n     = 0;
        mDuty = 0;
        mLed  = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        en   = 1'b1;
        mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge sysClk);
            #1;
            checks++;
            if (led !== 1'b0 || level !== 3'd0 || periodStart !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d led=%0b level=%0d ps=%0b required 0/0/0",
                         i, led, level, periodStart);
            end
        end
        @(negedge sysClk);
        rstN  = 1'b1;
        n     = 0;
        mDuty = 0;
        mLed  = 1'b0;
    endtask

    task automatic test_on_off();
        int b;
        en   = 1'b1;
        mode = 2'd1;
        for (int i = 0; i < 48; i++) begin
            tick();
            checks++;
            if (led !== mLed || (n > PER && led !== 1'b1)) begin
                errors++;
                $display("FAIL on_led n=%0d got %0b required %0b", n, led, mLed);
            end
        end
        mode = 2'd0;
        b = (n / PER + 1) * PER;
        for (int i = 0; i < 48; i++) begin
            tick();
            checks++;
            if (led !== mLed || (n > b && led !== 1'b0)) begin
                errors++;
                $display("FAIL off_led n=%0d got %0b required %0b", n, led, mLed);
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd1;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (led !== 1'b1 || level !== 3'(levelAt(n))) begin
            errors++;
            $display("FAIL pre_async n=%0d led=%0b level=%0d required 1/%0d",
                     n, led, level, levelAt(n));
        end
        #3 rstN = 1'b0;
        #1;
        checks++;
        if (led !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL async_reset led=%0b level=%0d required 0/0", led, level);
        end
        do_reset();
    endtask

    task automatic test_breathe();
        int hi, curDuty, expHi;
        hi = 0;
        curDuty = 0;
        do_reset();
        en   = 1'b1;
        mode = 2'd3;
        for (int i = 0; i < TRI * STEPC + STEPC; i++) begin
            tick();
            checks++;
            if (led !== mLed || level !== 3'(levelAt(n)) || periodStart !== (n % PER == 0)) begin
                errors++;
                $display("FAIL breathe n=%0d led=%0b/%0b level=%0d/%0d ps=%0b",
                         n, led, mLed, level, levelAt(n), periodStart);
            end
            if (n % PER == 1) begin
                hi = 0;
                curDuty = mDuty;
            end
            hi += int'(led);
            if (n % PER == 0 && n >= 2 * PER) begin
                expHi = (curDuty == MAXV) ? PER : P * curDuty;
                checks++;
                if (hi !== expHi) begin
                    errors++;
                    $display("FAIL breathe_highs n=%0d duty=%0d got %0d required %0d",
                             n, curDuty, hi, expHi);
                end
            end
        end
    endtask

    task automatic test_mid_change();
        int b;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * PER && !found; i++) begin
            tick();
            if ((n / P) % (MAXV + 1) == 3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_wait pwmCnt=3 not reached, got n=%0d required found", n);
        end
        mode = 2'd1;
        b = (n / PER + 1) * PER;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (led !== mLed || (n > b && led !== 1'b1)) begin
                errors++;
                $display("FAIL mid_change n=%0d got %0b required %0b", n, led, mLed);
            end
        end
    endtask

    task automatic test_blink();
        do_reset();
        en   = 1'b1;
        mode = 2'd2;
        for (int i = 0; i < TRI * STEPC + STEPC; i++) begin
            tick();
            checks++;
            if (led !== mLed || level !== 3'(levelAt(n))) begin
                errors++;
                $display("FAIL blink n=%0d led=%0b/%0b level=%0d/%0d",
                         n, led, mLed, level, levelAt(n));
            end
        end
    endtask

    task automatic test_enable();
        int pre;
        do_reset();
        en   = 1'b1;
        mode = 2'd3;
        pre = $urandom_range(60, 120);
        for (int i = 0; i < pre; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (led !== 1'b0 || level !== 3'(levelAt(n))) begin
                errors++;
                $display("FAIL en_gate n=%0d led=%0b level=%0d required 0/%0d",
                         n, led, level, levelAt(n));
            end
        end
        en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (led !== mLed || level !== 3'(levelAt(n))) begin
                errors++;
                $display("FAIL en_resume n=%0d led=%0b/%0b level=%0d/%0d",
                         n, led, mLed, level, levelAt(n));
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 12; seg++) begin
            mode = 2'($urandom_range(0, 3));
            en   = ($urandom % 4) != 0;
            len  = $urandom_range(5, 60);
            for (int i = 0; i < len; i++) begin
                tick();
                checks++;
                if (led !== mLed || level !== 3'(levelAt(n)) || periodStart !== (n % PER == 0)) begin
                    errors++;
                    $display("FAIL random n=%0d mode=%0d en=%0b led=%0b/%0b level=%0d/%0d",
                             n, mode, en, led, mLed, level, levelAt(n));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_on_off();
        test_async_reset();
        test_breathe();
        test_mid_change();
        test_blink();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
